register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width in bits; legal values are 16 and 32.
REQ-002 Parameter DEPTH_LOG2, default 4, SHALL set the number of entries to 2**DEPTH_LOG2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 wr_en  input  1  SHALL be the write strobe.
REQ-006 wr_addr  input  DEPTH_LOG2  SHALL be the write entry index.
REQ-007 wr_data  input  WIDTH  SHALL be the write data.
REQ-008 rd_req  input  1  SHALL indicate that a read request is presented.
REQ-009 rd_addr  input  DEPTH_LOG2  SHALL be the read entry index, sampled on acceptance.
REQ-010 rd_req_ready  output  1  SHALL indicate that the bank can accept a read request this cycle.
REQ-011 rd_valid  output  1  SHALL indicate that rd_data holds a read response.
REQ-012 rd_data  output  WIDTH  SHALL be the registered read response.
REQ-013 rd_ready  input  1  SHALL indicate that the consumer takes the response this cycle.

Function
REQ-014 Storage SHALL be 2**DEPTH_LOG2 entries of WIDTH bits each.
REQ-015 When wr_en=1 and reset=0, entry[wr_addr] SHALL take wr_data at the next edge.
REQ-016 Writes SHALL never stall and SHALL proceed independently of read state.
REQ-017 rd_req_ready SHALL be combinational and SHALL equal (!rd_valid || rd_ready) while reset=0.
REQ-018 rd_req_ready SHALL be 0 while reset=1.
REQ-019 A read SHALL be accepted in any cycle where rd_req=1 and rd_req_ready=1.
REQ-020 Read latency SHALL be 1 cycle: after an accepted read, rd_valid SHALL be 1 and rd_data SHALL be valid at the next edge.
REQ-021 The response SHALL be entry[rd_addr] as sampled at acceptance.
REQ-022 Bypass: if acceptance coincides with wr_en=1 and wr_addr==rd_addr, the response SHALL be wr_data.
REQ-023 While rd_valid=1 and rd_ready=0, rd_valid and rd_data SHALL hold.
REQ-024 Held responses SHALL be unaffected by later writes to the same entry (snapshot semantics).
REQ-025 If rd_valid=1 and rd_ready=1 with no new acceptance, rd_valid SHALL go to 0 at the next edge; rd_data SHALL hold its last value.
REQ-026 If rd_valid=1 and rd_ready=1 with a new acceptance in the same cycle, rd_valid SHALL stay 1 and rd_data SHALL update (back-to-back, one response per cycle).
REQ-027 The read side SHALL be a two-state FSM:
  - IDLE (rd_valid=0): acceptance moves to FULL.
  - FULL (rd_valid=1): rd_ready with acceptance stays in FULL; rd_ready without acceptance moves to IDLE; otherwise holds FULL.
REQ-028 Address arithmetic SHALL use the full DEPTH_LOG2 bits with no wrap or overflow cases; every index is legal.
REQ-029 rd_req=1 while rd_req_ready=0 SHALL be ignored; it SHALL not be queued.

Reset
REQ-030 With reset=1 at an edge, all entries SHALL become 0, rd_valid SHALL become 0, rd_data SHALL become 0, and the FSM SHALL enter IDLE.
REQ-031 Reset SHALL take priority over a coincident write or read acceptance; both SHALL be discarded.
REQ-032 Reset asserted while in FULL SHALL drop the pending response without rd_ready.

Verification
REQ-033 Write/read: write 0xDEADBEEF to entry 3, then read entry 3 with rd_ready=1 -> rd_valid=1 and rd_data=0xDEADBEEF exactly one cycle after acceptance.
REQ-034 Bypass: entry 5=0x11111111; in the same cycle write 0x22222222 to entry 5 and request a read of entry 5 -> response is 0x22222222.
REQ-035 Backpressure: read entry 2 (holding 0xA5A5A5A5) with rd_ready=0 for 4 cycles while writing 0x0 to entry 2 -> rd_data stays 0xA5A5A5A5, rd_req_ready=0, and a new rd_req is ignored; raise rd_ready -> rd_valid falls next cycle.
REQ-036 Streaming: rd_req=1 and rd_ready=1 continuously over addresses 0..15 -> 16 consecutive responses with rd_valid=1 every cycle, in order, with no gaps.
REQ-037 Reset mid-operation: fill all entries with nonzero data and hold a response in FULL, then pulse reset for 1 cycle -> rd_valid=0, rd_data=0, and subsequent reads of every entry return 0.
REQ-038 Parameterization: with WIDTH=16 and DEPTH_LOG2=2, write 0xBEEF to entry 3 and read it back -> 0xBEEF.

Source files
------------

// File: rtl/register_bank.sv
// Register bank with one write port and a registered, flow-controlled read port.
// Reads return a snapshot taken at acceptance; same-cycle writes to the read entry are forwarded.
//
// state | meaning
// IDLE  | no response held, rd_valid=0
// FULL  | response held in rd_data until rd_ready, rd_valid=1
module register_bank #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_req,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic                  rd_req_ready,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  rd_ready
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rd_accept;
    logic [WIDTH-1:0] rd_data_nxt;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_req_ready = 1'b0;
        rd_accept    = 1'b0;
        if (!reset) begin
            rd_req_ready = (state == IDLE) || rd_ready;
        end
        rd_accept = rd_req && rd_req_ready;
        case (state)
            IDLE: if (rd_accept) state_nxt = FULL;
            FULL: if (rd_ready && !rd_accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_valid = (state == FULL);

    // A write landing on the entry being read this cycle wins over the stored value.
    assign rd_data_nxt = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_accept) begin
            rd_data <= rd_data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus random traffic
// compared against an array-based reference model; a second narrow instance covers WIDTH=16.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic        rd_req_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;

    logic        n_reset;
    logic        n_wr_en;
    logic [1:0]  n_wr_addr;
    logic [15:0] n_wr_data;
    logic        n_rd_req;
    logic [1:0]  n_rd_addr;
    logic        n_rd_req_ready;
    logic        n_rd_valid;
    logic [15:0] n_rd_data;
    logic        n_rd_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [16];
    logic        m_valid;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    register_bank dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_req_ready(rd_req_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
    );

    register_bank #(.WIDTH(16), .DEPTH_LOG2(2)) dut_n (
        .clk(clk), .reset(n_reset), .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
        .rd_req(n_rd_req), .rd_addr(n_rd_addr), .rd_req_ready(n_rd_req_ready),
        .rd_valid(n_rd_valid), .rd_data(n_rd_data), .rd_ready(n_rd_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive after the falling edge, check ready before the
    // rising edge, advance the model at the edge, check response at the next falling edge.
    task automatic cycle(input logic rst, input logic we, input logic [3:0] wa,
                         input logic [31:0] wd, input logic rq, input logic [3:0] ra,
                         input logic rr);
        logic        acc;
        logic [31:0] resp;
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_req = rq; rd_addr = ra; rd_ready = rr;
        #1;
        chk("rd_req_ready", {31'b0, rd_req_ready}, {31'b0, !rst && (!m_valid || rr)});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            acc  = rq && (!m_valid || rr);
            resp = (we && wa == ra) ? wd : m_mem[ra];
            if (we) m_mem[wa] = wd;
            if (acc) begin
                m_valid = 1'b1;
                m_data  = resp;
            end else if (rr) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
        chk("rd_data", rd_data, m_data);
    endtask

    task automatic ncycle(input logic rst, input logic we, input logic [1:0] wa,
                          input logic [15:0] wd, input logic rq, input logic [1:0] ra,
                          input logic rr);
        n_reset = rst; n_wr_en = we; n_wr_addr = wa; n_wr_data = wd;
        n_rd_req = rq; n_rd_addr = ra; n_rd_ready = rr;
        @(negedge clk);
    endtask

    initial begin
        m_valid = 1'b0;
        m_data  = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        n_reset = 1'b1; n_wr_en = 1'b0; n_wr_addr = '0; n_wr_data = '0;
        n_rd_req = 1'b0; n_rd_addr = '0; n_rd_ready = 1'b0;
        @(negedge clk);

        // Reset with a coincident write and read, both discarded.
        cycle(1, 1, 4'd7, 32'h1234_5678, 1, 4'd7, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", {31'b0, rd_valid}, 32'd0);
        cycle(0, 0, 0, 0, 1, 4'd7, 1);
        chk("reset_discards_write", rd_data, 32'd0);

        // Plain write then read with one-cycle latency.
        cycle(0, 1, 4'd3, 32'hDEAD_BEEF, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 4'd3, 1);
        chk("wr_rd_valid", {31'b0, rd_valid}, 32'd1);
        chk("wr_rd_data", rd_data, 32'hDEAD_BEEF);

        // Same-cycle write forwarding.
        cycle(0, 1, 4'd5, 32'h1111_1111, 0, 0, 1);
        cycle(0, 1, 4'd5, 32'h2222_2222, 1, 4'd5, 1);
        chk("bypass", rd_data, 32'h2222_2222);

        // Backpressure with snapshot semantics and ignored requests.
        cycle(0, 1, 4'd2, 32'hA5A5_A5A5, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 4'd2, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 4'd2, 32'h0, 1, 4'd9, 0);
            chk("bp_hold", rd_data, 32'hA5A5_A5A5);
            chk("bp_ready", {31'b0, rd_req_ready}, 32'd0);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("bp_release", {31'b0, rd_valid}, 32'd0);
        chk("bp_data_holds", rd_data, 32'hA5A5_A5A5);

        // Streaming, one response per cycle.
        for (int i = 0; i < 16; i++) cycle(0, 1, i[3:0], 32'hC000_0000 + i * 32'h0101, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 0, 0, 1, i[3:0], 1);
            chk("stream_valid", {31'b0, rd_valid}, 32'd1);
            chk("stream_data", rd_data, 32'hC000_0000 + i * 32'h0101);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Reset while a response is held.
        for (int i = 0; i < 16; i++) cycle(0, 1, i[3:0], 32'h5000_0001 + i, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 4'd6, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 4'd1, 32'hFFFF_FFFF, 1, 4'd1, 0);
        chk("mid_reset_valid", {31'b0, rd_valid}, 32'd0);
        chk("mid_reset_data", rd_data, 32'd0);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 0, 0, 1, i[3:0], 1);
            chk("post_reset_entry", rd_data, 32'd0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0);
        end

        // Narrow instance.
        ncycle(1, 0, 0, 0, 0, 0, 0);
        chk("n_reset_valid", {31'b0, n_rd_valid}, 32'd0);
        ncycle(0, 1, 2'd3, 16'hBEEF, 0, 0, 1);
        ncycle(0, 0, 0, 0, 1, 2'd3, 1);
        chk("n_valid", {31'b0, n_rd_valid}, 32'd1);
        chk("n_data", {16'b0, n_rd_data}, 32'h0000_BEEF);
        ncycle(0, 0, 0, 0, 1, 2'd0, 1);
        chk("n_other_entry", {16'b0, n_rd_data}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
